// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C single-register master sequencer.
package i2c_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        RSTART,
        RX_BYTE,
        TX_NACK,
        STOP,
        DONE
    } state_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_e;

    // Which byte the next TX_BYTE / RX_BYTE slot group belongs to.
    typedef enum logic [1:0] {PH_DEVW, PH_REG, PH_WDATA, PH_DEVR} phase_e;

    localparam int unsigned SLOTS_WR = 29;
    localparam int unsigned SLOTS_RD = 39;

endpackage

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-period divider: pulses o_qtick once every CLK_DIV enabled cycles.
module i2c_qtick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_qtick
);

    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 16'd1;
        end
    end

    assign o_qtick = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C master performing one single-register write or read per host command,
// driving SCL/SDA open-drain through output enables.
module i2c_reg_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 125,
    parameter int unsigned ACK_ABORT = 1
) (
    input  logic       ti_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_e     r_state;
    state_e     w_state_next;
    quarter_e   r_qtr;
    phase_e     r_phase;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_rw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic       r_nack;
    logic       r_ack_err;
    logic [7:0] r_rd_data;

    logic w_busy;
    logic w_accept;
    logic w_qtick;
    logic w_slot_end;
    logic w_scl_low;

    assign w_busy     = (r_state != IDLE) && (r_state != DONE);
    assign w_accept   = start && !w_busy;
    assign w_slot_end = w_qtick && (r_qtr == Q3);
    assign w_scl_low  = (r_qtr == Q0) || (r_qtr == Q3);

    i2c_qtick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .i_clk   (ti_clk),
        .i_rst_n (rst_n),
        .i_clr   (w_accept),
        .i_en    (w_busy),
        .o_qtick (w_qtick)
    );

    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: w_state_next = w_accept ? START : IDLE;
            START:      if (w_slot_end) w_state_next = TX_BYTE;
            TX_BYTE:    if (w_slot_end && r_bit == 3'd7) w_state_next = RX_ACK;
            RX_ACK: begin
                if (w_slot_end) begin
                    if (r_nack) begin
                        w_state_next = STOP;
                    end else begin
                        unique case (r_phase)
                            PH_DEVW:  w_state_next = TX_BYTE;
                            PH_REG:   w_state_next = r_rw ? RSTART : TX_BYTE;
                            PH_WDATA: w_state_next = STOP;
                            PH_DEVR:  w_state_next = RX_BYTE;
                            default:  w_state_next = STOP;
                        endcase
                    end
                end
            end
            RSTART:     if (w_slot_end) w_state_next = TX_BYTE;
            RX_BYTE:    if (w_slot_end && r_bit == 3'd7) w_state_next = TX_NACK;
            TX_NACK:    if (w_slot_end) w_state_next = STOP;
            STOP:       if (w_slot_end) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // ACK and read bits are sampled at the end of Q2; bytes advance at the end of Q3.
    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            r_qtr     <= Q0;
            r_phase   <= PH_DEVW;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_dev     <= '0;
            r_reg     <= '0;
            r_wdata   <= '0;
            r_nack    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rd_data <= '0;
        end else if (w_accept) begin
            r_qtr     <= Q0;
            r_phase   <= PH_DEVW;
            r_bit     <= '0;
            r_shift   <= {dev_addr, 1'b0};
            r_rw      <= rw;
            r_dev     <= dev_addr;
            r_reg     <= reg_addr;
            r_wdata   <= wr_data;
            r_nack    <= 1'b0;
            r_ack_err <= 1'b0;
        end else if (w_qtick) begin
            r_qtr <= quarter_e'(2'(r_qtr + 2'd1));
            if (r_qtr == Q2) begin
                if (r_state == RX_ACK && sda_in) begin
                    r_ack_err <= 1'b1;
                    r_nack    <= (ACK_ABORT != 0);
                end
                if (r_state == RX_BYTE) begin
                    r_shift <= {r_shift[6:0], sda_in};
                end
            end
            if (r_qtr == Q3) begin
                case (r_state)
                    TX_BYTE: begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                    RX_BYTE: r_bit <= r_bit + 3'd1;
                    RX_ACK: begin
                        if (r_phase == PH_DEVW) begin
                            r_phase <= PH_REG;
                            r_shift <= r_reg;
                        end else if (r_phase == PH_REG) begin
                            r_phase <= r_rw ? PH_DEVR : PH_WDATA;
                            r_shift <= r_rw ? {r_dev, 1'b1} : r_wdata;
                        end
                    end
                    STOP: if (r_rw && !r_ack_err) r_rd_data <= r_shift;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (r_state)
            START: begin
                scl_oe = (r_qtr == Q3);
                sda_oe = (r_qtr == Q2) || (r_qtr == Q3);
            end
            RSTART: begin
                scl_oe = w_scl_low;
                sda_oe = (r_qtr == Q2) || (r_qtr == Q3);
            end
            TX_BYTE: begin
                scl_oe = w_scl_low;
                sda_oe = ~r_shift[7];
            end
            RX_ACK, RX_BYTE, TX_NACK: scl_oe = w_scl_low;
            STOP: begin
                scl_oe = (r_qtr == Q0);
                sda_oe = (r_qtr == Q0) || (r_qtr == Q1);
            end
            default: ;
        endcase
    end

    assign busy    = w_busy;
    assign done    = (r_state == DONE);
    assign ack_err = r_ack_err;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: slave/bus-monitor model plus vector table.
module tb_i2c_reg_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int EV_S = 'h400;
    localparam int EV_P = 'h800;

    logic       ti_clk;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    i2c_reg_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .ACK_ABORT (1)
    ) u_dut (
        .ti_clk   (ti_clk),
        .rst_n    (rst_n),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rd_data  (rd_data),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    initial ti_clk = 1'b0;
    always #5 ti_clk = ~ti_clk;

    // Slave model and bus monitor, sampled on the falling edge.
    logic       s_pull = 1'b0;
    logic       slave_nack_addr = 1'b0;
    logic [7:0] slave_rd_byte = 8'h00;
    int         s_bits = 0;
    bit         s_tx = 1'b0;
    bit         s_first = 1'b0;
    bit         s_ackbit = 1'b0;
    logic [7:0] s_byte = 8'h00;
    logic       m_scl_prev = 1'b1;
    logic       m_sda_prev = 1'b1;
    logic       scl_now;
    logic       sda_now;
    int         log_q[$];
    int         done_cnt = 0;

    assign sda_in = ~(sda_oe | s_pull);

    always @(negedge ti_clk) begin
        scl_now = ~scl_oe;
        sda_now = sda_in;
        if (!rst_n) begin
            s_pull = 1'b0;
            s_bits = 0;
            s_tx   = 1'b0;
        end else if (m_scl_prev && scl_now && m_sda_prev && !sda_now) begin
            log_q.push_back(EV_S);
            s_bits  = 0;
            s_tx    = 1'b0;
            s_first = 1'b1;
            s_pull  = 1'b0;
        end else if (m_scl_prev && scl_now && !m_sda_prev && sda_now) begin
            log_q.push_back(EV_P);
            s_bits = 0;
            s_tx   = 1'b0;
            s_pull = 1'b0;
        end else if (!m_scl_prev && scl_now) begin
            if (s_bits < 8) begin
                s_byte = {s_byte[6:0], sda_now};
                s_bits++;
            end else if (s_bits == 8) begin
                s_ackbit = sda_now;
                s_bits   = 9;
                log_q.push_back((s_ackbit ? 256 : 0) + int'(s_byte));
            end
        end else if (m_scl_prev && !scl_now) begin
            if (s_bits == 8) begin
                s_pull = !s_tx && !(slave_nack_addr && s_first);
            end else if (s_bits == 9) begin
                s_bits = 0;
                if (!s_tx && s_first && s_byte[0] && !s_ackbit) begin
                    s_tx   = 1'b1;
                    s_pull = ~slave_rd_byte[7];
                end else begin
                    s_tx   = 1'b0;
                    s_pull = 1'b0;
                end
                s_first = 1'b0;
            end else if (s_tx && s_bits >= 1 && s_bits <= 7) begin
                s_pull = ~slave_rd_byte[7 - s_bits];
            end else begin
                s_pull = 1'b0;
            end
        end
        m_scl_prev = scl_now;
        m_sda_prev = sda_in;
        if (done) done_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string tag, input int len, input int exp[8]);
        check({tag, "_log_len"}, log_q.size(), len);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_log%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, exp[i]);
        end
    endtask

    // Returns the number of cycles from the acceptance cycle to the done cycle.
    task automatic run_txn(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_ra,
                           input logic [7:0] t_wd, input int inject_at, output int cyc);
        @(negedge ti_clk);
        rw       = t_rw;
        dev_addr = t_dev;
        reg_addr = t_ra;
        wr_data  = t_wd;
        start    = 1'b1;
        @(negedge ti_clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_rise", int'(busy), 1);
        check("ack_err_clr", int'(ack_err), 0);
        while (!done && cyc < 2000) begin
            if (cyc == inject_at) begin
                start    = 1'b1;
                rw       = ~t_rw;
                dev_addr = 7'h11;
                reg_addr = 8'h77;
                wr_data  = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge ti_clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
        logic       nack_addr;
        logic [7:0] rd_byte;
        int         exp_cyc;
        int         exp_err;
        int         exp_rd;
        int         exp_len;
        int         exp_log[8];
    } vec_t;

    vec_t vecs[6];
    int   wr_log[8];
    int   cyc;
    int   d0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rw: 1'b0, dev: 7'h50, ra: 8'h12, wd: 8'hA5, nack_addr: 1'b0, rd_byte: 8'h00,
                    exp_cyc: 465, exp_err: 0, exp_rd: 'h00, exp_len: 5,
                    exp_log: '{EV_S, 'h0A0, 'h012, 'h0A5, EV_P, 0, 0, 0}};
        vecs[1] = '{rw: 1'b1, dev: 7'h50, ra: 8'h03, wd: 8'h00, nack_addr: 1'b0, rd_byte: 8'h3C,
                    exp_cyc: 625, exp_err: 0, exp_rd: 'h3C, exp_len: 7,
                    exp_log: '{EV_S, 'h0A0, 'h003, EV_S, 'h0A1, 'h13C, EV_P, 0}};
        vecs[2] = '{rw: 1'b1, dev: 7'h50, ra: 8'h44, wd: 8'h00, nack_addr: 1'b1, rd_byte: 8'h99,
                    exp_cyc: 177, exp_err: 1, exp_rd: 'h3C, exp_len: 3,
                    exp_log: '{EV_S, 'h1A0, EV_P, 0, 0, 0, 0, 0}};
        vecs[3] = '{rw: 1'b0, dev: 7'h2B, ra: 8'hFF, wd: 8'h00, nack_addr: 1'b0, rd_byte: 8'h00,
                    exp_cyc: 465, exp_err: 0, exp_rd: 'h3C, exp_len: 5,
                    exp_log: '{EV_S, 'h056, 'h0FF, 'h000, EV_P, 0, 0, 0}};
        vecs[4] = '{rw: 1'b1, dev: 7'h11, ra: 8'h80, wd: 8'h00, nack_addr: 1'b0, rd_byte: 8'hC3,
                    exp_cyc: 625, exp_err: 0, exp_rd: 'hC3, exp_len: 7,
                    exp_log: '{EV_S, 'h022, 'h080, EV_S, 'h023, 'h1C3, EV_P, 0}};
        vecs[5] = '{rw: 1'b0, dev: 7'h7F, ra: 8'h01, wd: 8'h55, nack_addr: 1'b1, rd_byte: 8'h00,
                    exp_cyc: 177, exp_err: 1, exp_rd: 'hC3, exp_len: 3,
                    exp_log: '{EV_S, 'h1FE, EV_P, 0, 0, 0, 0, 0}};
        wr_log = '{EV_S, 'h0A0, 'h012, 'h0A5, EV_P, 0, 0, 0};

        rst_n    = 1'b0;
        start    = 1'b0;
        rw       = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        wr_data  = '0;
        repeat (3) @(negedge ti_clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ack_err", int'(ack_err), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_scl_oe", int'(scl_oe), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge ti_clk);

        for (int i = 0; i < 6; i++) begin
            slave_nack_addr = vecs[i].nack_addr;
            slave_rd_byte   = vecs[i].rd_byte;
            log_q.delete();
            run_txn(vecs[i].rw, vecs[i].dev, vecs[i].ra, vecs[i].wd, 0, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
            check($sformatf("v%0d_ack_err", i), int'(ack_err), vecs[i].exp_err);
            check($sformatf("v%0d_rd_data", i), int'(rd_data), vecs[i].exp_rd);
            @(negedge ti_clk);
            check($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
            check_log($sformatf("v%0d", i), vecs[i].exp_len, vecs[i].exp_log);
            repeat (5) @(negedge ti_clk);
        end

        // A start pulse mid-transaction must be ignored.
        slave_nack_addr = 1'b0;
        slave_rd_byte   = 8'h5A;
        log_q.delete();
        d0 = done_cnt;
        run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 100, cyc);
        check("busy_start_cycles", cyc, int'(4 * CLK_DIV * i2c_ctrl_pkg::SLOTS_WR + 1));
        check_log("busy_start", 5, wr_log);
        repeat (700) @(negedge ti_clk);
        check("busy_start_done_count", done_cnt - d0, 1);
        check("busy_start_idle", int'(busy), 0);
        check("busy_start_rd_data", int'(rd_data), 'hC3);

        // Reset in the middle of the first TX_BYTE.
        log_q.delete();
        @(negedge ti_clk);
        rw       = 1'b0;
        dev_addr = 7'h50;
        reg_addr = 8'h12;
        wr_data  = 8'hA5;
        start    = 1'b1;
        @(negedge ti_clk);
        start = 1'b0;
        repeat (60) @(negedge ti_clk);
        check("midrst_busy_before", int'(busy), 1);
        d0    = done_cnt;
        rst_n = 1'b0;
        @(negedge ti_clk);
        check("midrst_scl_oe", int'(scl_oe), 0);
        check("midrst_sda_oe", int'(sda_oe), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        repeat (3) @(negedge ti_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge ti_clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_rd_data", int'(rd_data), 0);

        log_q.delete();
        run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 0, cyc);
        check("after_rst_cycles", cyc, int'(4 * CLK_DIV * i2c_ctrl_pkg::SLOTS_WR + 1));
        check("after_rst_ack_err", int'(ack_err), 0);
        @(negedge ti_clk);
        check_log("after_rst", 5, wr_log);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
